pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//  Power-up and recovery sequencer for the fabric PLL (50 MHz refclk -> 40 MHz CAN core clock).
//  Holds the PLL in reset, waits for lock, qualifies lock stability, then releases clk_ready to the
//  CAN clock-domain reset synchronizers. Detects loss of lock, re-initialises with bounded retries,
//  and flags permanent failure to the host. Runs on the free-running refclk, never on the PLL output.
// PARAMETERS
//  RST_HOLD_CYCLES      16     refclk cycles pll_rst held high per attempt (>=1)
//  LOCK_TIMEOUT_CYCLES  50000  max cycles in WAIT_LOCK before a retry (1 ms @ 50 MHz)
//  LOCK_STABLE_CYCLES   1024   consecutive synced-locked cycles required before RUN
//  MAX_RETRIES          3      failed attempts tolerated before FAIL (>=1)
//  SYNC_STAGES          2      flops in the pll_locked synchronizer (>=2)
// PORTS
//  refclk      in   1   free-running 50 MHz reference clock, also drives the PLL
//  rst_n       in   1   asynchronous active-low reset
//  pll_locked  in   1   PLL locked, asynchronous to refclk
//  relock_req  in   1   host request: restart the sequence (single-cycle pulse, level tolerated)
//  pll_rst     out  1   to PLL rst, active high
//  clk_ready   out  1   PLL output valid and stable; gates downstream reset release
//  lock_lost   out  1   one-cycle pulse on loss of lock while in RUN
//  fail        out  1   sticky: MAX_RETRIES attempts exhausted
//  retry_cnt   out  $clog2(MAX_RETRIES+1)  failed attempts in current sequence
//  state       out  3   current FSM state (debug/CSR readback)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=HOLD, pll_rst=1, clk_ready=0, lock_lost=0, fail=0, retry_cnt=0, counters=0.
//  - pll_locked passes SYNC_STAGES flops -> lk_s; all decisions use lk_s only.
//  - One shared cycle counter, cleared on every state entry; all outputs registered.
//  - HOLD (0): pll_rst=1. After RST_HOLD_CYCLES cycles in HOLD -> WAIT_LOCK.
//  - WAIT_LOCK (1): pll_rst=0. lk_s=1 -> STABLE. Counter reaches LOCK_TIMEOUT_CYCLES -> attempt failure.
//  - STABLE (2): lk_s=1 for LOCK_STABLE_CYCLES consecutive cycles -> RUN. lk_s=0 -> back to WAIT_LOCK
//    with timeout counter restarted (a glitch is not an attempt failure).
//  - RUN (3): clk_ready=1 from first RUN cycle; retry_cnt cleared on entry. lk_s=0 -> clk_ready=0 and
//    lock_lost=1 the next cycle, state -> HOLD; retry_cnt NOT incremented (loss after lock is a new sequence).
//  - Attempt failure: retry_cnt+1; if new value == MAX_RETRIES -> FAIL, else -> HOLD.
//  - FAIL (4): pll_rst=1, clk_ready=0, fail=1; remains until relock_req or rst_n.
//  - relock_req: in any state -> HOLD next cycle, retry_cnt=0, fail=0, clk_ready=0. Highest priority:
//    coincident loss of lock in RUN produces no lock_lost pulse; coincident timeout does not count.
//  - retry_cnt saturates at MAX_RETRIES; never wraps. Counter width $clog2(max param)+1, no wrap in use.
//  - Encodings 5-7 unreachable; if decoded, go to HOLD.
//  - Latency from rst_n release, PLL locking instantly: pll_rst falls after RST_HOLD_CYCLES; clk_ready
//    rises SYNC_STAGES + LOCK_STABLE_CYCLES + 2 cycles (±1) later.
// STRUCTURE
//  - pll_ctrl_pkg: state enum (HOLD, WAIT_LOCK, STABLE, RUN, FAIL) with fixed 3-bit encodings above,
//    shared with the CSR block that decodes `state`.
//  - Sub-module sync_bit (SYNC_STAGES-deep flop chain, async active-low reset to 0) for pll_locked.
//  - Top: FSM + cycle counter + retry counter + output registers.
// TESTING  (RST_HOLD=4, TIMEOUT=20, STABLE=8, MAX_RETRIES=2, SYNC=2)
//  1 Release rst_n, PLL model asserts locked 3 cycles after pll_rst falls -> pll_rst high 4 cycles,
//    clk_ready rises ~12 cycles after locked, retry_cnt=0, fail=0.
//  2 locked never asserts -> two 20-cycle WAIT_LOCK windows, retry_cnt 1 then 2, fail=1, state=4, pll_rst=1.
//  3 In STABLE drop locked for 1 cycle at stable count 5 -> back to WAIT_LOCK, no retry increment,
//    RUN reached only after 8 fresh consecutive locked cycles.
//  4 In RUN drop locked -> exactly one lock_lost pulse, clk_ready low, HOLD, full re-sequence to RUN.
//  5 From FAIL pulse relock_req -> fail=0, retry_cnt=0, HOLD next cycle; also relock_req coincident
//    with lock drop in RUN -> HOLD, lock_lost stays 0.
//  6 Assert rst_n=0 mid-STABLE -> all outputs at reset values asynchronously, same cycle.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL reset sequencer: state encodings (also decoded by the CSR block)
// and a small elaboration-time helper.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level (used for pll_locked).
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL power-up/recovery sequencer on refclk: holds PLL reset, waits for and qualifies lock,
// releases clk_ready, retries on timeout and latches a sticky failure after MAX_RETRIES attempts.
module pll_reset_sequencer
    import pll_ctrl_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int SYNC_STAGES         = 2
) (
    input  logic                             refclk,
    input  logic                             rst_n,
    input  logic                             pll_locked,
    input  logic                             relock_req,
    output logic                             pll_rst,
    output logic                             clk_ready,
    output logic                             lock_lost,
    output logic                             fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
    output logic [2:0]                       state
);

    localparam int CNT_W = $clog2(max3(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)) + 1;
    localparam int RTY_W = $clog2(MAX_RETRIES + 1);
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRIES);

    logic             lk_s;
    pll_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RTY_W-1:0] retry_q, retry_d, retry_inc;
    logic             pll_rst_q, pll_rst_d;
    logic             clk_ready_q, clk_ready_d;
    logic             lock_lost_q, lock_lost_d;
    logic             fail_q, fail_d;
    logic             cnt_freeze;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk_s)
    );

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;
        cnt_freeze  = 1'b0;
        retry_inc   = (retry_q == RTY_MAX) ? retry_q : retry_q + 1'b1;

        case (state_q)
            HOLD: begin
                if (cnt_q == CNT_W'(RST_HOLD_CYCLES - 1)) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lk_s) begin
                    state_d = STABLE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RTY_MAX) ? FAIL : HOLD;
                end
            end
            STABLE: begin
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
                cnt_freeze = 1'b1;
                if (!lk_s) begin
                    state_d     = HOLD;
                    lock_lost_d = 1'b1;
                end
            end
            FAIL: begin
                cnt_freeze = 1'b1;
            end
            default: begin
                state_d = HOLD;
            end
        endcase

        // A host relock request overrides every other event in the same cycle.
        if (relock_req) begin
            state_d     = HOLD;
            retry_d     = '0;
            lock_lost_d = 1'b0;
        end

        if ((state_d != state_q) || relock_req) begin
            cnt_d = '0;
        end else if (cnt_freeze) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        pll_rst_d   = (state_d == HOLD) || (state_d == FAIL);
        clk_ready_d = (state_d == RUN);
        fail_d      = (state_d == FAIL);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            clk_ready_q <= 1'b0;
            lock_lost_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            clk_ready_q <= clk_ready_d;
            lock_lost_q <= lock_lost_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign clk_ready = clk_ready_q;
    assign lock_lost = lock_lost_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: a segment-level reference model turns each run's
// locked/relock waveforms into a list of expected output changes that a monitor matches.
module tb_pll_reset_sequencer;
    import pll_ctrl_pkg::*;

    localparam int H    = 4;
    localparam int T    = 20;
    localparam int S    = 8;
    localparam int MR   = 2;
    localparam int SY   = 2;
    localparam int RW   = $clog2(MR + 1);
    localparam int VW   = 7 + RW;
    localparam int MAXL = 200;
    localparam logic [VW-1:0] RESET_VEC = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, {RW{1'b0}}};

    logic          refclk     = 1'b0;
    logic          rst_n      = 1'b1;
    logic          pll_locked = 1'b0;
    logic          relock_req = 1'b0;
    logic          pll_rst;
    logic          clk_ready;
    logic          lock_lost;
    logic          fail;
    logic [RW-1:0] retry_cnt;
    logic [2:0]    state;

    typedef struct {
        int            cyc;
        logic [VW-1:0] vec;
    } evt_t;

    evt_t       expQ[$];
    bit         lockArr[MAXL];
    bit         relockArr[MAXL];
    pll_state_e expSt[MAXL];
    int         expRetry[MAXL];
    bit         expLost[MAXL];
    int         runLen;
    bit         monOn  = 1'b0;
    int         errors = 0;
    int         checks = 0;

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES     (H),
        .LOCK_TIMEOUT_CYCLES (T),
        .LOCK_STABLE_CYCLES  (S),
        .MAX_RETRIES         (MR),
        .SYNC_STAGES         (SY)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .clk_ready  (clk_ready),
        .lock_lost  (lock_lost),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .state      (state)
    );

    always #5 refclk = ~refclk;

    function automatic logic [VW-1:0] dutVec();
        return {state, pll_rst, clk_ready, lock_lost, fail, retry_cnt};
    endfunction

    function automatic logic [VW-1:0] expVec(input int k);
        pll_state_e s;
        s = expSt[k];
        return {s, (s == HOLD) || (s == FAIL), s == RUN, expLost[k], s == FAIL, RW'(expRetry[k])};
    endfunction

    // Locked level as seen by the sequencer's decision at edge k (after the synchronizer).
    function automatic bit lkAt(input int k);
        return (k - SY >= 0) ? lockArr[k - SY] : 1'b0;
    endfunction

    function automatic int firstRelock(input int a, input int b);
        for (int k = a; k <= b && k < runLen; k++) if (relockArr[k]) return k;
        return -1;
    endfunction

    function automatic int firstLk(input int a, input int b, input bit v);
        for (int k = ((a < 0) ? 0 : a); k <= b && k < runLen; k++) if (lkAt(k) == v) return k;
        return -1;
    endfunction

    // Walks the run phase by phase: each phase finds its exit edge by scanning the input
    // waveforms, then stamps its state/retry value over the edges it occupies.
    task automatic runModel();
        pll_state_e ph, nph;
        int e, nxt, rty, nrty, r, z, l;
        bit pulse;
        ph = HOLD; e = -1; rty = 0;
        for (int k = 0; k < MAXL; k++) expLost[k] = 1'b0;
        while (e < runLen) begin
            pulse = 1'b0; nph = ph; nrty = rty; nxt = runLen;
            case (ph)
                HOLD: begin
                    r = firstRelock(e + 1, e + H);
                    if (r >= 0) begin nxt = r; nrty = 0; end
                    else begin nxt = e + H; nph = WAIT_LOCK; end
                end
                WAIT_LOCK: begin
                    l = firstLk(e + 1, e + T, 1'b1);
                    r = firstRelock(e + 1, e + T);
                    if (r >= 0 && (l < 0 || r <= l)) begin nxt = r; nph = HOLD; nrty = 0; end
                    else if (l >= 0) begin nxt = l; nph = STABLE; end
                    else begin
                        nxt  = e + T;
                        nrty = (rty + 1 > MR) ? MR : rty + 1;
                        nph  = (nrty == MR) ? FAIL : HOLD;
                    end
                end
                STABLE: begin
                    z = firstLk(e + 1, e + S, 1'b0);
                    r = firstRelock(e + 1, e + S);
                    if (r >= 0 && (z < 0 || r <= z)) begin nxt = r; nph = HOLD; nrty = 0; end
                    else if (z >= 0) begin nxt = z; nph = WAIT_LOCK; end
                    else begin nxt = e + S; nph = RUN; nrty = 0; end
                end
                RUN: begin
                    z = firstLk(e + 1, runLen - 1, 1'b0);
                    r = firstRelock(e + 1, runLen - 1);
                    if (r >= 0 && (z < 0 || r <= z)) begin nxt = r; nph = HOLD; nrty = 0; end
                    else if (z >= 0) begin nxt = z; nph = HOLD; pulse = 1'b1; end
                end
                default: begin
                    r = firstRelock(e + 1, runLen - 1);
                    if (r >= 0) begin nxt = r; nph = HOLD; nrty = 0; end
                end
            endcase
            for (int k = ((e < 0) ? 0 : e); k < nxt && k < runLen; k++) begin
                expSt[k] = ph; expRetry[k] = rty;
            end
            if (pulse && nxt < runLen) expLost[nxt] = 1'b1;
            ph = nph; rty = nrty; e = nxt;
        end
    endtask

    task automatic buildRun(input int kind);
        int t0, d, rl;
        bit lv;
        for (int k = 0; k < MAXL; k++) begin lockArr[k] = 1'b0; relockArr[k] = 1'b0; end
        t0 = H + int'($urandom_range(0, 3));
        case (kind)
            0: begin
                t0 = int'($urandom_range(0, 8)) + H;
                runLen = t0 + SY + S + 15;
                for (int k = t0; k < runLen; k++) lockArr[k] = 1'b1;
            end
            1: runLen = H + T + H + T + 12;
            2: begin
                runLen = t0 + 40;
                for (int k = t0; k < runLen; k++) lockArr[k] = 1'b1;
                lockArr[t0 + 6] = 1'b0;
            end
            3: begin
                d = t0 + SY + S + 2 + int'($urandom_range(0, 6));
                runLen = d + 40;
                for (int k = t0; k < runLen; k++) lockArr[k] = 1'b1;
                for (int k = d; k <= d + int'($urandom_range(0, 2)); k++) lockArr[k] = 1'b0;
            end
            4: begin
                rl = 60 + int'($urandom_range(0, 4));
                runLen = rl + 60;
                relockArr[rl] = 1'b1;
                for (int k = rl + int'($urandom_range(0, 25)); k < runLen; k++) lockArr[k] = 1'b1;
            end
            5: begin
                d = t0 + SY + S + 3 + int'($urandom_range(0, 4));
                runLen = d + 40;
                for (int k = t0; k < runLen; k++) lockArr[k] = 1'b1;
                lockArr[d] = 1'b0; lockArr[d + 1] = 1'b0;
                relockArr[d + SY] = 1'b1;
            end
            6: begin
                t0 = H + int'($urandom_range(0, 2));
                runLen = t0 + SY + 4;
                for (int k = t0; k < runLen; k++) lockArr[k] = 1'b1;
            end
            7: begin
                t0 = H + T + H + int'($urandom_range(0, 10));
                runLen = t0 + 35;
                for (int k = t0; k < runLen; k++) lockArr[k] = 1'b1;
            end
            default: begin
                runLen = 150;
                lv = 1'b0;
                for (int k = 0; k < runLen; k++) begin
                    if ($urandom_range(0, 11) == 0) lv = ~lv;
                    lockArr[k]   = lv;
                    relockArr[k] = ($urandom_range(0, 49) == 0);
                end
            end
        endcase
    endtask

    task automatic checkOutput(input string name, input int actCyc, input int reqCyc,
                               input logic [VW-1:0] act, input logic [VW-1:0] req);
        checks++;
        if (act !== req || actCyc != reqCyc) begin
            errors++;
            $display("[TB] FAIL %s: got %b at cycle %0d, required %b at cycle %0d",
                     name, act, actCyc, req, reqCyc);
        end
    endtask

    // Drives one run from reset release; expectations are queued before the first edge.
    task automatic applyStimulus();
        logic [VW-1:0] prev, v;
        evt_t ev;
        @(negedge refclk);
        @(negedge refclk);
        prev = RESET_VEC;
        for (int k = 0; k < runLen; k++) begin
            v = expVec(k);
            if (v != prev) begin ev.cyc = k; ev.vec = v; expQ.push_back(ev); end
            prev = v;
        end
        rst_n = 1'b1; pll_locked = lockArr[0]; relock_req = relockArr[0];
        #1 monOn = 1'b1;
        for (int k = 1; k < runLen; k++) begin
            @(negedge refclk);
            pll_locked = lockArr[k]; relock_req = relockArr[k];
        end
        @(negedge refclk);
        #2;
        monOn = 1'b0; rst_n = 1'b0; pll_locked = 1'b0; relock_req = 1'b0;
        #2;
    endtask

    // Monitor: checks reset values right after each asynchronous reset assertion and matches
    // every change of the DUT outputs against the head of the expectation queue.
    initial begin : monitor
        logic [VW-1:0] cur, prevDut;
        evt_t e;
        int monK;
        logic lastRst;
        lastRst = 1'b1; monK = 0; prevDut = RESET_VEC;
        forever begin
            @(negedge refclk or negedge rst_n);
            if (lastRst && !rst_n) begin
                #1;
                checkOutput("reset_values", 0, 0, dutVec(), RESET_VEC);
                while (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("missing_event", -1, e.cyc, prevDut, e.vec);
                end
                monK = 0; prevDut = RESET_VEC;
            end else if (monOn) begin
                cur = dutVec();
                while (expQ.size() > 0 && expQ[0].cyc < monK) begin
                    e = expQ.pop_front();
                    checkOutput("missed_event", monK, e.cyc, cur, e.vec);
                end
                if (cur != prevDut) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_change", monK, -1, cur, prevDut);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("output_event", monK, e.cyc, cur, e.vec);
                    end
                end
                prevDut = cur;
                monK++;
            end else begin
                monK = 0;
            end
            lastRst = rst_n;
        end
    end

    initial begin : driver
        int kinds[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 8, 8, 8, 8, 8, 8, 0};
        #3 rst_n = 1'b0;
        foreach (kinds[i]) begin
            buildRun(kinds[i]);
            runModel();
            $display("[TB] run %0d kind %0d length %0d", i, kinds[i], runLen);
            applyStimulus();
        end
        #20;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
